// File: rtl/mram_word_writer_if.sv
// Bundles the shift-register side strobe/data inputs and the MRAM pin outputs of mram_word_writer.
// en is a qualifier rather than a valid/ready pair: every cycle with en=1 is one bit strobe, and no back-pressure exists.
interface mram_word_writer_if #(
   parameter int BUS_WIDTH  = 3,
   parameter int ADDR_WIDTH = 4
);
   logic                  en;
   logic [BUS_WIDTH-1:0]  data_in;
   logic                  clr_ovr;
   logic [ADDR_WIDTH-1:0] mram_addr;
   logic [BUS_WIDTH-1:0]  mram_data;
   logic                  mram_ce_n;
   logic                  mram_we_n;
   logic                  busy;
   logic                  overrun;
   logic [1:0]            dbg_state;

   modport master (
      output en, data_in, clr_ovr,
      input  mram_addr, mram_data, mram_ce_n, mram_we_n, busy, overrun, dbg_state
   );

   modport slave (
      input  en, data_in, clr_ovr,
      output mram_addr, mram_data, mram_ce_n, mram_we_n, busy, overrun, dbg_state
   );
endinterface

// File: rtl/mram_word_writer.sv
// Counts shift strobes into words and plays out one timed CE_n/WE_n MRAM write per captured word.
// The address auto-increments after every completed write.
module mram_word_writer #(
   parameter int BUS_WIDTH    = 3,
   parameter int ADDR_WIDTH   = 4,
   parameter int SETUP_CYCLES = 2,
   parameter int WE_CYCLES    = 4,
   parameter int HOLD_CYCLES  = 2
) (
   input logic clk,
   input logic rst,
   mram_word_writer_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, WRITE = 2'd2, HOLD = 2'd3} state_e;

   localparam int MAX_PH0 = (SETUP_CYCLES > WE_CYCLES) ? SETUP_CYCLES : WE_CYCLES;
   localparam int MAX_PH  = (MAX_PH0 > HOLD_CYCLES) ? MAX_PH0 : HOLD_CYCLES;
   localparam int PW      = $clog2(MAX_PH + 1);
   localparam int CW      = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;

   state_e                state_q, state_d;
   logic [PW-1:0]         ph_q, ph_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  cap_pend_q, cap_pend_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BUS_WIDTH-1:0]  data_q, data_d;
   logic                  ce_n_q, ce_n_d;
   logic                  we_n_q, we_n_d;
   logic                  overrun_q, overrun_d;
   logic                  last_bit;
   logic                  capture;
   logic                  drop;

   assign last_bit = bus.en && (bit_cnt_q == CW'(BUS_WIDTH - 1));
   assign capture  = cap_pend_q && (state_q == IDLE);
   // A word finishing while any write phase (HOLD included) is active is lost.
   assign drop     = cap_pend_q && (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         ph_q       <= '0;
         bit_cnt_q  <= '0;
         cap_pend_q <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         ce_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         bit_cnt_q  <= bit_cnt_d;
         cap_pend_q <= cap_pend_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         ce_n_q     <= ce_n_d;
         we_n_q     <= we_n_d;
         overrun_q  <= overrun_d;
      end
   end

   // Phase counter restarts at zero on every state entry and exits on count N-1.
   always_comb begin
      state_d = state_q;
      ph_d    = ph_q;
      unique case (state_q)
         IDLE: begin
            if (capture) begin
               state_d = SETUP;
               ph_d    = '0;
            end
         end
         SETUP: begin
            if (ph_q == PW'(SETUP_CYCLES - 1)) begin
               state_d = WRITE;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + PW'(1);
            end
         end
         WRITE: begin
            if (ph_q == PW'(WE_CYCLES - 1)) begin
               state_d = HOLD;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + PW'(1);
            end
         end
         HOLD: begin
            if (ph_q == PW'(HOLD_CYCLES - 1)) begin
               state_d = IDLE;
               ph_d    = '0;
            end else begin
               ph_d = ph_q + PW'(1);
            end
         end
      endcase
   end

   always_comb begin
      ce_n_d     = (state_d == IDLE);
      we_n_d     = (state_d != WRITE);
      data_d     = capture ? bus.data_in : data_q;
      addr_d     = (state_q == HOLD && state_d == IDLE) ? addr_q + ADDR_WIDTH'(1) : addr_q;
      cap_pend_d = last_bit;
      bit_cnt_d  = bit_cnt_q;
      if (bus.en) begin
         bit_cnt_d = last_bit ? '0 : bit_cnt_q + CW'(1);
      end
      overrun_d  = drop | (overrun_q & ~bus.clr_ovr);
   end

   assign bus.mram_addr = addr_q;
   assign bus.mram_data = data_q;
   assign bus.mram_ce_n = ce_n_q;
   assign bus.mram_we_n = we_n_q;
   assign bus.busy      = cap_pend_q | (state_q != IDLE);
   assign bus.overrun   = overrun_q;
   assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_mram_word_writer.sv
// Directed bench for mram_word_writer: a driver issues words, a negedge monitor checks each MRAM write
// cycle (address, data, CE_n/WE_n timing) against an expected queue filled by the driver.
module tb_mram_word_writer;
   localparam int BW = 3;
   localparam int AW = 4;
   localparam int W  = AW + BW;

   logic clk;
   logic rst;

   mram_word_writer_if #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

   mram_word_writer #(
      .BUS_WIDTH(BW), .ADDR_WIDTH(AW),
      .SETUP_CYCLES(2), .WE_CYCLES(4), .HOLD_CYCLES(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0]  exp_q[$];
   logic [AW-1:0] exp_addr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.en = 1'b0;
      end
   endtask

   task automatic strobes(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.en = 1'b1;
      end
   endtask

   task automatic finish_word(input logic [BW-1:0] d, input bit accepted);
      @(negedge clk);
      bus.en      = 1'b0;
      bus.data_in = d;
      if (accepted) begin
         exp_q.push_back({exp_addr, d});
         exp_addr = exp_addr + AW'(1);
      end
   endtask

   task automatic send_word(input logic [BW-1:0] d, input bit accepted);
      strobes(BW);
      finish_word(d, accepted);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b0;
      repeat (n) begin
         @(negedge clk);
         bus.en = ~bus.en;
      end
      bus.en   = 1'b0;
      rst      = 1'b1;
      exp_addr = '0;
   endtask

   // monitor: one write cycle spans the negedge samples with ce_n low
   bit            in_wr = 0;
   int            k, we_first, we_last, we_cnt;
   bit            stable_ok;
   logic [AW-1:0] a0;
   logic [BW-1:0] d0;
   logic [W-1:0]  exp_w;

   always @(negedge clk) begin
      if (!rst) begin
         in_wr = 0;
      end else if (!bus.mram_ce_n) begin
         if (!in_wr) begin
            in_wr     = 1;
            k         = 1;
            we_first  = 0;
            we_last   = 0;
            we_cnt    = 0;
            stable_ok = 1;
            a0        = bus.mram_addr;
            d0        = bus.mram_data;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write addr=%0h data=%0b", a0, d0);
            end else begin
               exp_w = exp_q.pop_front();
               check("write_addr", 32'(a0), 32'(exp_w[W-1:BW]));
               check("write_data", 32'(d0), 32'(exp_w[BW-1:0]));
            end
         end else begin
            k++;
            if (bus.mram_addr !== a0 || bus.mram_data !== d0) stable_ok = 0;
         end
         if (!bus.mram_we_n) begin
            if (we_cnt == 0) we_first = k;
            we_last = k;
            we_cnt++;
         end
      end else if (in_wr) begin
         in_wr = 0;
         check("ce_low_cycles", 32'(k), 32'd8);
         check("we_low_first", 32'(we_first), 32'd3);
         check("we_low_last", 32'(we_last), 32'd6);
         check("we_low_count", 32'(we_cnt), 32'd4);
         check("addr_data_stable", 32'(stable_ok), 32'd1);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst         = 1'b1;
      bus.en      = 1'b0;
      bus.data_in = '0;
      bus.clr_ovr = 1'b0;
      exp_addr    = '0;

      // 1: reset with en toggling
      do_reset(2);
      check("rst_ce_n", 32'(bus.mram_ce_n), 32'd1);
      check("rst_we_n", 32'(bus.mram_we_n), 32'd1);
      check("rst_addr", 32'(bus.mram_addr), 32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);

      // 2: single word 101
      send_word(3'b101, 1);
      @(negedge clk);
      check("t2_busy", 32'(bus.busy), 32'd1);
      check("t2_ce_low", 32'(bus.mram_ce_n), 32'd0);
      idle(10);
      check("t2_addr_after", 32'(bus.mram_addr), 32'd1);
      check("t2_ce_high", 32'(bus.mram_ce_n), 32'd1);

      // 3: two strobes are not a word
      strobes(2);
      idle(6);
      check("t3_no_write_ce", 32'(bus.mram_ce_n), 32'd1);
      check("t3_not_busy", 32'(bus.busy), 32'd0);
      strobes(1);
      finish_word(3'b010, 1);
      idle(10);
      check("t3_addr_after", 32'(bus.mram_addr), 32'd2);

      // 4: 17 words at 12-clock spacing, address wraps 15 -> 0
      do_reset(2);
      for (int i = 0; i < 17; i++) begin
         send_word(BW'(i * 5 + 1), 1);
         idle(8);
      end
      idle(2);
      check("t4_addr_wrapped", 32'(bus.mram_addr), 32'd1);
      check("t4_overrun", 32'(bus.overrun), 32'd0);

      // 5: second word lands mid-write and is dropped
      send_word(3'b110, 1);
      send_word(3'b001, 0);
      idle(12);
      check("t5_overrun_set", 32'(bus.overrun), 32'd1);
      check("t5_addr", 32'(bus.mram_addr), 32'(exp_addr));
      @(negedge clk);
      bus.clr_ovr = 1'b1;
      @(negedge clk);
      bus.clr_ovr = 1'b0;
      check("t5_overrun_clr", 32'(bus.overrun), 32'd0);

      // 6: reset during WRITE with a partial word counted
      send_word(3'b011, 1);
      n = 0;
      while (bus.mram_we_n && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t6_reached_write", 32'(bus.mram_we_n), 32'd0);
      strobes(1);
      @(negedge clk);
      bus.en = 1'b0;
      rst    = 1'b0;
      @(negedge clk);
      rst      = 1'b1;
      exp_addr = '0;
      check("t6_we_n", 32'(bus.mram_we_n), 32'd1);
      check("t6_ce_n", 32'(bus.mram_ce_n), 32'd1);
      check("t6_addr", 32'(bus.mram_addr), 32'd0);
      check("t6_busy", 32'(bus.busy), 32'd0);
      send_word(3'b111, 1);
      idle(12);
      check("t6_addr_after", 32'(bus.mram_addr), 32'd1);
      check("t6_overrun", 32'(bus.overrun), 32'd0);

      // final report
      check("exp_q_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
